// File: rtl/gfx_pkg.sv
// Shared definitions for the CPU-to-VRAM write buffer: register map, drain
// FSM states, the queued write record and the debug view of the block.
package gfx_pkg;

  localparam logic [1:0] DMA_ADDR_LO   = 2'b00;
  localparam logic [1:0] DMA_ADDR_HI   = 2'b01;
  localparam logic [1:0] DMA_ADDR_DATA = 2'b10;
  localparam logic [1:0] DMA_ADDR_CTRL = 2'b11;

  localparam int CTRL_STEP256_BIT = 0;
  localparam int CTRL_OVF_CLR_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } dma_state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } vram_wr_t;

  typedef struct packed {
    dma_state_e  state;
    logic        drive;
    logic        step256;
    logic        fifo_empty;
    logic [15:0] ptr;
  } dma_dbg_t;

  // 16-bit modulo advance; a row step of 256 wraps 16'hFFxx to 16'h00xx.
  function automatic logic [15:0] ptr_advance(input logic [15:0] ptr, input logic step256);
    return step256 ? (ptr + 16'h0100) : (ptr + 16'h0001);
  endfunction

endpackage

// File: rtl/gfx_vram_dma_if.sv
// CPU control bus into the VRAM write buffer. The CPU strobe is asynchronous
// to the pixel clock; addr/data must stay stable while the strobe is low.
interface gfx_vram_dma_if;
  logic       ce_b;
  logic       ce2;
  logic       w_b;
  logic [1:0] addr;
  logic [7:0] data;

  modport master (output ce_b, ce2, w_b, addr, data);
  modport slave  (input  ce_b, ce2, w_b, addr, data);
endinterface

// File: rtl/gfx_sync_fifo.sv
// DEPTH-entry synchronous FIFO of VRAM write records with a registered head.
// Pushes into a full FIFO are ignored; pops of an empty FIFO are ignored.
module gfx_sync_fifo
  import gfx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic     i_clk,
  input  logic     i_rst_b,
  input  logic     push,
  input  vram_wr_t din,
  input  logic     pop,
  output vram_wr_t head,
  output logic     full,
  output logic     empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  vram_wr_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gfx_vram_dma.sv
// CPU-to-VRAM write buffer: synchronized CPU register writes feed a FIFO that
// drains into VRAM only while the VGA generator leaves the shared bus free.
module gfx_vram_dma
  import gfx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_b,
  gfx_vram_dma_if.slave        ctrl,
  input  logic                 i_free_vbus_b,
  output wire  [15:0]          o_vaddr,
  output wire  [7:0]           o_vdata,
  output logic                 o_vwe_b,
  output logic                 o_busy_b,
  output logic                 o_full,
  output logic                 o_overflow,
  output dma_dbg_t             o_dbg
);

  logic       sel_raw;
  logic       sel_meta;
  logic       sel_sync;
  logic       sel_prev;
  logic       wr_evt;
  logic       data_wr;
  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  vram_wr_t   fifo_head;
  vram_wr_t   push_rec;
  vram_wr_t   out_q;
  logic [15:0] ptr;
  logic       step256;
  logic       overflow;
  dma_state_e state;
  logic       drive;

  assign sel_raw = ~ctrl.w_b & ~ctrl.ce_b & ctrl.ce2;

  // Two-flop synchronizer plus one delay flop for rising-edge detection.
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      sel_meta <= 1'b0;
      sel_sync <= 1'b0;
      sel_prev <= 1'b0;
    end else begin
      sel_meta <= sel_raw;
      sel_sync <= sel_meta;
      sel_prev <= sel_sync;
    end
  end

  assign wr_evt   = sel_sync & ~sel_prev;
  assign data_wr  = wr_evt & (ctrl.addr == DMA_ADDR_DATA);
  assign push     = data_wr & ~fifo_full;
  assign push_rec = '{addr: ptr, data: ctrl.data};

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      ptr      <= '0;
      step256  <= 1'b0;
      overflow <= 1'b0;
    end else if (wr_evt) begin
      case (ctrl.addr)
        DMA_ADDR_LO: ptr[7:0]  <= ctrl.data;
        DMA_ADDR_HI: ptr[15:8] <= ctrl.data;
        DMA_ADDR_DATA: begin
          if (fifo_full) overflow <= 1'b1;
          else           ptr      <= ptr_advance(ptr, step256);
        end
        default: begin
          step256 <= ctrl.data[CTRL_STEP256_BIT];
          if (ctrl.data[CTRL_OVF_CLR_BIT]) overflow <= 1'b0;
        end
      endcase
    end
  end

  gfx_sync_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_b (i_rst_b),
    .push    (push),
    .din     (push_rec),
    .pop     (pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Any busy cycle before HOLD aborts to IDLE; the head stays queued for retry.
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state <= ST_IDLE;
      out_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty && !i_free_vbus_b) begin
            state <= ST_SETUP;
            out_q <= fifo_head;
          end
        end
        ST_SETUP:  state <= i_free_vbus_b ? ST_IDLE : ST_STROBE;
        ST_STROBE: state <= i_free_vbus_b ? ST_IDLE : ST_HOLD;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign pop   = (state == ST_HOLD);
  assign drive = (state != ST_IDLE) & ~i_free_vbus_b;

  assign o_vaddr    = drive ? out_q.addr : 16'hzzzz;
  assign o_vdata    = drive ? out_q.data : 8'hzz;
  assign o_vwe_b    = ~((state == ST_STROBE) & ~i_free_vbus_b);
  assign o_full     = fifo_full;
  assign o_busy_b   = fifo_empty & (state == ST_IDLE);
  assign o_overflow = overflow;

  assign o_dbg = '{state: state, drive: drive, step256: step256,
                   fifo_empty: fifo_empty, ptr: ptr};

endmodule
